train_sequencer: RTL and testbench

TRAIN_SEQUENCER -- requirements
Module: train_sequencer

---
 rtl/train_sequencer_if.sv | 39 +++
 rtl/train_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_train_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/train_sequencer_if.sv
// Sample-write, run-control and layer-drive signals of the training sequencer.
// The slave modport is the sequencer side; the master modport is the driving side.
interface train_sequencer_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_input_1;
  logic [31:0] wr_input_2;
  logic [31:0] wr_target_1;
  logic [31:0] wr_target_2;
  logic        start;
  logic        abort;
  logic [15:0] epochs;
  logic [31:0] o_2_1;
  logic [31:0] o_2_2;
  logic [31:0] input_1;
  logic [31:0] input_2;
  logic [31:0] target_1;
  logic [31:0] target_2;
  logic        update;
  logic        busy;
  logic        done;
  logic [1:0]  sample_idx;
  logic [15:0] epoch_cnt;
  logic [31:0] epoch_err;

  modport slave (
    input  wr_en, wr_addr, wr_input_1, wr_input_2, wr_target_1, wr_target_2,
    input  start, abort, epochs, o_2_1, o_2_2,
    output input_1, input_2, target_1, target_2, update, busy, done,
    output sample_idx, epoch_cnt, epoch_err
  );

  modport master (
    output wr_en, wr_addr, wr_input_1, wr_input_2, wr_target_1, wr_target_2,
    output start, abort, epochs, o_2_1, o_2_2,
    input  input_1, input_2, target_1, target_2, update, busy, done,
    input  sample_idx, epoch_cnt, epoch_err
  );
endinterface

// File: rtl/train_sequencer.sv
// Epoch/sample sequencer for a small training network: presents each stored sample,
// waits for the network to settle, accumulates absolute error and strobes weight updates.
module train_sequencer #(
  parameter int SETTLE_CYCLES = 10,
  parameter int NSAMPLES      = 4
) (
  input logic              clk,
  input logic              reset,
  train_sequencer_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] UPDATE = 3'd3;
  localparam logic [2:0] FINISH = 3'd4;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] LAST_IDX    = 2'(NSAMPLES - 1);

  // Differences are formed at 33 bits so the full signed Q8.24 range never overflows.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] d;
    logic [32:0] n;
    d = {a[31], a} - {b[31], b};
    n = 33'd0 - d;
    if (d[32]) begin
      abs_diff = n[31:0];
    end else begin
      abs_diff = d[31:0];
    end
  endfunction

  function automatic logic [31:0] sat_add3(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    logic [33:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c};
    if (s[33:32] != 2'b00) begin
      sat_add3 = 32'hFFFF_FFFF;
    end else begin
      sat_add3 = s[31:0];
    end
  endfunction

  logic [2:0]  state_r;
  logic [7:0]  settle_cnt_r;
  logic [15:0] epochs_r;
  logic [31:0] acc_r;
  logic [31:0] err_next_s;
  logic [31:0] input_1_r, input_2_r, target_1_r, target_2_r;
  logic        update_r, busy_r, done_r;
  logic [1:0]  sample_idx_r;
  logic [15:0] epoch_cnt_r;
  logic [31:0] epoch_err_r;

  logic [31:0] mem_in1_r [NSAMPLES];
  logic [31:0] mem_in2_r [NSAMPLES];
  logic [31:0] mem_t1_r  [NSAMPLES];
  logic [31:0] mem_t2_r  [NSAMPLES];

  // Accumulator value including the sample currently being settled.
  always_comb begin
    err_next_s = 32'd0;
    err_next_s = sat_add3(acc_r, abs_diff(target_1_r, bus.o_2_1),
                          abs_diff(target_2_r, bus.o_2_2));
  end

  // Sample memory: writable only while the sequencer is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSAMPLES; i++) begin
        mem_in1_r[i] <= 32'd0;
        mem_in2_r[i] <= 32'd0;
        mem_t1_r[i]  <= 32'd0;
        mem_t2_r[i]  <= 32'd0;
      end
    end else if (bus.wr_en && (state_r == IDLE)) begin
      mem_in1_r[bus.wr_addr] <= bus.wr_input_1;
      mem_in2_r[bus.wr_addr] <= bus.wr_input_2;
      mem_t1_r[bus.wr_addr]  <= bus.wr_target_1;
      mem_t2_r[bus.wr_addr]  <= bus.wr_target_2;
    end else begin
      mem_in1_r[0] <= mem_in1_r[0];
    end
  end

  // Main sequencer FSM with registered status and layer-drive outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      settle_cnt_r <= 8'd0;
      epochs_r     <= 16'd0;
      acc_r        <= 32'd0;
      input_1_r    <= 32'd0;
      input_2_r    <= 32'd0;
      target_1_r   <= 32'd0;
      target_2_r   <= 32'd0;
      update_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      sample_idx_r <= 2'd0;
      epoch_cnt_r  <= 16'd0;
      epoch_err_r  <= 32'd0;
    end else if (bus.abort) begin
      state_r  <= IDLE;
      update_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      acc_r    <= 32'd0;
    end else begin
      update_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          if (bus.start && (bus.epochs != 16'd0)) begin
            state_r      <= LOAD;
            busy_r       <= 1'b1;
            sample_idx_r <= 2'd0;
            epoch_cnt_r  <= 16'd0;
            acc_r        <= 32'd0;
            epochs_r     <= bus.epochs;
          end else if (bus.start) begin
            done_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          input_1_r    <= mem_in1_r[sample_idx_r];
          input_2_r    <= mem_in2_r[sample_idx_r];
          target_1_r   <= mem_t1_r[sample_idx_r];
          target_2_r   <= mem_t2_r[sample_idx_r];
          settle_cnt_r <= 8'd0;
          state_r      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            acc_r    <= err_next_s;
            state_r  <= UPDATE;
            update_r <= 1'b1;
          end else begin
            settle_cnt_r <= settle_cnt_r + 8'd1;
          end
        end
        UPDATE: begin
          if (sample_idx_r != LAST_IDX) begin
            sample_idx_r <= sample_idx_r + 2'd1;
            state_r      <= LOAD;
          end else begin
            epoch_err_r <= acc_r;
            acc_r       <= 32'd0;
            epoch_cnt_r <= epoch_cnt_r + 16'd1;
            if ((epoch_cnt_r + 16'd1) == epochs_r) begin
              state_r <= FINISH;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r      <= LOAD;
              sample_idx_r <= 2'd0;
            end
          end
        end
        FINISH: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.input_1    = input_1_r;
  assign bus.input_2    = input_2_r;
  assign bus.target_1   = target_1_r;
  assign bus.target_2   = target_2_r;
  assign bus.update     = update_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.sample_idx = sample_idx_r;
  assign bus.epoch_cnt  = epoch_cnt_r;
  assign bus.epoch_err  = epoch_err_r;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed self-checking bench for train_sequencer (SETTLE_CYCLES=10, four samples).
module tb_train_sequencer;
  localparam int S = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  train_sequencer_if bus ();

  train_sequencer #(.SETTLE_CYCLES(S), .NSAMPLES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic write_sample(input logic [1:0] addr, input logic [31:0] in1,
                              input logic [31:0] in2, input logic [31:0] t1,
                              input logic [31:0] t2);
    bus.wr_en       = 1'b1;
    bus.wr_addr     = addr;
    bus.wr_input_1  = in1;
    bus.wr_input_2  = in2;
    bus.wr_target_1 = t1;
    bus.wr_target_2 = t2;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic load_std;
    for (int i = 0; i < 4; i++) begin
      write_sample(2'(i), 32'h0800_0000 + 32'(i), 32'h0500_0000, 32'h0100_0000, 32'h0);
    end
  endtask

  // Start a job and watch it to completion within a cycle budget.
  task automatic run_job(input logic [15:0] ep, input int max_cyc, output int n_upd,
                         output int first_cyc, output int done_cyc,
                         output logic [31:0] first_in1, output logic [31:0] second_in1);
    n_upd = 0; first_cyc = 0; done_cyc = 0; first_in1 = 32'h0; second_in1 = 32'h0;
    bus.epochs = ep;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc && done_cyc == 0; cyc++) begin
      if (bus.update === 1'b1) begin
        if (n_upd == 0) begin first_cyc = cyc; first_in1 = bus.input_1; end
        if (n_upd == 1) second_in1 = bus.input_1;
        n_upd++;
      end
      if (bus.done === 1'b1) done_cyc = cyc;
      tick();
    end
  endtask

  task automatic test_reset;
    tick(); tick();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
    n_checks++; if (bus.update !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got upd=%0h done=%0h want 0", bus.update, bus.done); end
    n_checks++; if (bus.input_1 !== 32'h0 || bus.target_2 !== 32'h0) begin n_fail++; $display("FAIL reset_drive: got %h/%h want 0", bus.input_1, bus.target_2); end
    n_checks++; if (bus.epoch_cnt !== 16'h0 || bus.epoch_err !== 32'h0 || bus.sample_idx !== 2'd0) begin n_fail++; $display("FAIL reset_status: got %h/%h/%h want 0", bus.epoch_cnt, bus.epoch_err, bus.sample_idx); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_run;
    int n_upd = 0, last = 0, dcnt = 0, dcyc = 0, exp_cyc;
    load_std();
    bus.o_2_1 = 32'h0080_0000;
    bus.o_2_2 = 32'h0040_0000;
    bus.epochs = 16'd2;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      if (bus.update === 1'b1) begin
        exp_cyc = (n_upd == 0) ? (S + 2) : (last + S + 2);
        n_checks++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL run_update_cycle: got %0d want %0d", cyc, exp_cyc); end
        n_checks++; if (bus.sample_idx !== 2'(n_upd % 4)) begin n_fail++; $display("FAIL run_sample_idx: got %0d want %0d", bus.sample_idx, n_upd % 4); end
        n_checks++; if (bus.input_1 !== 32'h0800_0000 + 32'(n_upd % 4)) begin n_fail++; $display("FAIL run_input_1: got %h want %h", bus.input_1, 32'h0800_0000 + 32'(n_upd % 4)); end
        last = cyc;
        n_upd++;
      end
      if (bus.done === 1'b1) begin dcnt++; dcyc = cyc; end
      if (cyc == 30) begin bus.start = 1'b1; bus.epochs = 16'd5; end
      else begin bus.start = 1'b0; bus.epochs = 16'd5; end
      tick();
    end
    bus.start = 1'b0;
    n_checks++; if (n_upd != 8) begin n_fail++; $display("FAIL run_update_count: got %0d want 8", n_upd); end
    n_checks++; if (dcnt != 1 || dcyc != last + 1) begin n_fail++; $display("FAIL run_done: got count %0d at %0d want 1 at %0d", dcnt, dcyc, last + 1); end
    n_checks++; if (bus.epoch_cnt !== 16'd2) begin n_fail++; $display("FAIL run_epoch_cnt: got %0d want 2", bus.epoch_cnt); end
    n_checks++; if (bus.epoch_err !== 32'h0300_0000) begin n_fail++; $display("FAIL run_epoch_err: got %h want 03000000", bus.epoch_err); end
  endtask

  task automatic test_epochs_zero;
    int n_upd = 0;
    bus.epochs = 16'd0;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    n_checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%0h busy=%0h want 1/0", bus.done, bus.busy); end
    n_checks++; if (bus.epoch_cnt !== 16'd2 || bus.epoch_err !== 32'h0300_0000) begin n_fail++; $display("FAIL zero_held: got %h/%h want 2/03000000", bus.epoch_cnt, bus.epoch_err); end
    tick();
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_width: got %0h want 0", bus.done); end
    for (int i = 0; i < 20; i++) begin
      if (bus.update === 1'b1 || bus.busy === 1'b1) n_upd++;
      tick();
    end
    n_checks++; if (n_upd != 0) begin n_fail++; $display("FAIL zero_no_update: got %0d active cycles want 0", n_upd); end
  endtask

  task automatic test_saturate;
    int n_upd, fc, dc;
    logic [31:0] f1, s1;
    for (int i = 0; i < 4; i++) write_sample(2'(i), 32'h0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    bus.o_2_1 = 32'h8000_0000;
    bus.o_2_2 = 32'h8000_0000;
    run_job(16'd1, 100, n_upd, fc, dc, f1, s1);
    n_checks++; if (n_upd != 4 || dc != 4 * (S + 2) + 1) begin n_fail++; $display("FAIL sat_run: got %0d updates done at %0d want 4 at %0d", n_upd, dc, 4 * (S + 2) + 1); end
    n_checks++; if (bus.epoch_err !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_epoch_err: got %h want ffffffff", bus.epoch_err); end
    n_checks++; if (bus.epoch_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_epoch_cnt: got %0d want 1", bus.epoch_cnt); end
  endtask

  task automatic test_abort;
    int n_upd = 0, n_after = 0, fc, dc, nu;
    logic [31:0] f1, s1;
    load_std();
    bus.o_2_1 = 32'h0080_0000;
    bus.o_2_2 = 32'h0040_0000;
    bus.epochs = 16'd2;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (bus.update === 1'b1) n_upd++;
      if (cyc == 30) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.update !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%0h upd=%0h want 0/0", bus.busy, bus.update); end
    for (int i = 0; i < 40; i++) begin
      if (bus.update === 1'b1 || bus.done === 1'b1) n_after++;
      tick();
    end
    n_checks++; if (n_upd != 2 || n_after != 0) begin n_fail++; $display("FAIL abort_pulses: got %0d before %0d after want 2/0", n_upd, n_after); end
    n_checks++; if (bus.epoch_cnt !== 16'd0 || bus.epoch_err !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL abort_held: got %h/%h want 0/ffffffff", bus.epoch_cnt, bus.epoch_err); end
    run_job(16'd1, 100, nu, fc, dc, f1, s1);
    n_checks++; if (fc != S + 2 || f1 !== 32'h0800_0000) begin n_fail++; $display("FAIL abort_restart: got first update %0d in1 %h want %0d 08000000", fc, f1, S + 2); end
    n_checks++; if (bus.epoch_err !== 32'h0300_0000 || dc == 0) begin n_fail++; $display("FAIL abort_restart_err: got %h done %0d want 03000000", bus.epoch_err, dc); end
  endtask

  task automatic test_write_busy;
    int nu, fc, dc, waited = 0;
    logic [31:0] f1, s1;
    bus.epochs = 16'd1;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wbusy_busy: got %0h want 1", bus.busy); end
    write_sample(2'd1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    while (bus.done !== 1'b1 && waited < 100) begin tick(); waited++; end
    n_checks++; if (waited >= 100) begin n_fail++; $display("FAIL wbusy_timeout: got %0d cycles want under 100", waited); end
    tick();
    run_job(16'd1, 100, nu, fc, dc, f1, s1);
    n_checks++; if (s1 !== 32'h0800_0001) begin n_fail++; $display("FAIL wbusy_mem: got %h want 08000001", s1); end
  endtask

  task automatic test_reset_midrun;
    int n_act = 0, nu, fc, dc;
    logic [31:0] f1, s1;
    bus.epochs = 16'd2;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.input_1 !== 32'h0 || bus.target_1 !== 32'h0) begin n_fail++; $display("FAIL mreset_drive: got busy=%0h in1=%h t1=%h want 0", bus.busy, bus.input_1, bus.target_1); end
    n_checks++; if (bus.epoch_err !== 32'h0 || bus.sample_idx !== 2'd0 || bus.update !== 1'b0) begin n_fail++; $display("FAIL mreset_status: got err=%h idx=%0d upd=%0h want 0", bus.epoch_err, bus.sample_idx, bus.update); end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.update === 1'b1 || bus.busy === 1'b1 || bus.done === 1'b1) n_act++;
      tick();
    end
    n_checks++; if (n_act != 0) begin n_fail++; $display("FAIL mreset_idle: got %0d active cycles want 0", n_act); end
    bus.o_2_1 = 32'hFF00_0000;
    bus.o_2_2 = 32'h0040_0000;
    run_job(16'd1, 100, nu, fc, dc, f1, s1);
    n_checks++; if (f1 !== 32'h0 || bus.epoch_err !== 32'h0500_0000) begin n_fail++; $display("FAIL mreset_mem: got in1=%h err=%h want 0/05000000", f1, bus.epoch_err); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0;
    bus.wr_input_1 = 32'h0; bus.wr_input_2 = 32'h0;
    bus.wr_target_1 = 32'h0; bus.wr_target_2 = 32'h0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.epochs = 16'd0;
    bus.o_2_1 = 32'h0; bus.o_2_2 = 32'h0;
    test_reset();
    test_full_run();
    test_epochs_zero();
    test_saturate();
    test_abort();
    test_write_busy();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
